// File: rtl/alu_acc_ctrl_if.sv
// alu_acc_ctrl_if: command and response handshake bundle for the accumulator ALU controller
interface alu_acc_ctrl_if #(parameter int LEN = 32);
  logic           cmd_valid;
  logic           cmd_ready;
  logic [1:0]     cmd_kind;
  logic [2:0]     cmd_op;
  logic [LEN-1:0] cmd_operand;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [LEN-1:0] rsp_data;
  logic           rsp_carry;
  logic           rsp_zero;
  logic           rsp_overflow;
  modport master (
    output cmd_valid, cmd_kind, cmd_op, cmd_operand, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_zero, rsp_overflow
  );
  modport slave (
    input  cmd_valid, cmd_kind, cmd_op, cmd_operand, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_zero, rsp_overflow
  );
endinterface

// File: rtl/alu_acc_ctrl.sv
// alu_acc_ctrl: accumulator ALU sequencer, one command in flight through IDLE -> CALC -> RESP
module alu_acc_ctrl #(
  parameter int LEN = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_acc_ctrl_if.slave  bus,
  output logic [LEN-1:0] acc_out
);
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
  localparam logic [1:0] K_LOAD = 2'd0;
  localparam logic [1:0] K_EXEC = 2'd1;
  localparam logic [1:0] K_READ = 2'd3;
  state_t         state, state_nx;
  logic [1:0]     kind;
  logic [2:0]     op;
  logic [LEN-1:0] opnd, acc, data, bx, res;
  logic [LEN:0]   sum;
  logic           carry, zero, ovf, cin, arith, ov, lt, eq;
  // Shared adder: subtract and both compares run as A + ~B + 1
  always_comb begin
    cin   = (op == 3'b001) || (op[2:1] == 2'b11);
    arith = (op[2:1] == 2'b00) || (op[2:1] == 2'b11);
    bx    = opnd ^ {LEN{cin}};
    sum   = {1'b0, acc} + {1'b0, bx} + {{LEN{1'b0}}, cin};
    ov    = (acc[LEN-1] == bx[LEN-1]) && (sum[LEN-1] != acc[LEN-1]);
    lt    = sum[LEN-1] ^ ov;
    eq    = sum[LEN-1:0] == '0;
    case (op)
      3'b000, 3'b001: res = sum[LEN-1:0];
      3'b010:         res = ~acc;
      3'b011:         res = acc & opnd;
      3'b100:         res = acc | opnd;
      3'b101:         res = acc ^ opnd;
      3'b110:         res = {{(LEN-1){1'b0}}, lt};
      default:        res = {{(LEN-1){1'b0}}, eq};
    endcase
  end
  always_comb begin
    state_nx = state == IDLE ? (bus.cmd_valid ? CALC : IDLE) :
               state == CALC ? RESP : (bus.rsp_ready ? IDLE : RESP);
    bus.cmd_ready = state == IDLE;
    bus.rsp_valid = state == RESP;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      kind  <= K_LOAD;
      op    <= '0;
      opnd  <= '0;
      acc   <= '0;
      data  <= '0;
      carry <= 1'b0;
      zero  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && bus.cmd_valid) begin
        kind <= bus.cmd_kind;
        op   <= bus.cmd_op;
        opnd <= bus.cmd_operand;
      end
      if (state == CALC) begin
        if (kind == K_READ) begin
          data <= acc;
        end else begin
          data  <= kind == K_LOAD ? opnd : res;
          zero  <= (kind == K_LOAD ? opnd : res) == '0;
          carry <= kind != K_LOAD && arith && (sum[LEN] ^ cin);
          ovf   <= kind != K_LOAD && arith && ov;
        end
        if (kind == K_LOAD) acc <= opnd;
        else if (kind == K_EXEC) acc <= res;
      end
    end
  end
  assign bus.rsp_data     = data;
  assign bus.rsp_carry    = carry;
  assign bus.rsp_zero     = zero;
  assign bus.rsp_overflow = ovf;
  assign acc_out          = acc;
endmodule
